// File: rtl/ula_scheduler_if.sv
// Signal bundle between the ULA scheduler, its two requesters and the shared ULA.
// The scheduler uses the slave modport; the environment (requesters plus ULA) uses master.
interface ula_scheduler_if #(
    parameter int W = 26
);
    logic         req0;
    logic         req1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [1:0]   cmd0;
    logic [1:0]   cmd1;
    logic         ack0;
    logic         ack1;
    logic [W-1:0] result;
    logic         carry;
    logic         err;
    logic         busy;
    logic         ula_start;
    logic [W-1:0] ula_a;
    logic [W-1:0] ula_b;
    logic [1:0]   ula_cmd;
    logic         ula_done;
    logic [W-1:0] ula_result;
    logic         ula_carry;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, cmd0, cmd1,
        input  ula_done, ula_result, ula_carry,
        output ack0, ack1, result, carry, err, busy,
        output ula_start, ula_a, ula_b, ula_cmd
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, cmd0, cmd1,
        output ula_done, ula_result, ula_carry,
        input  ack0, ack1, result, carry, err, busy,
        input  ula_start, ula_a, ula_b, ula_cmd
    );
endinterface

// File: rtl/ula_scheduler.sv
// Round-robin scheduler sharing one multi-cycle ULA between two requesters,
// with a stale-done guard and a wait timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no operation; arbitrate between req0/req1
//   S_ISSUE | operands latched; ula_start high for this one cycle
//   S_WAIT  | waiting for ula_done (first cycle ignores it); timeout count
//   S_RESP  | ack pulse to the granted requester; result/carry/err valid
module ula_scheduler #(
    parameter int W       = 26,
    parameter int TIMEOUT = 65535
) (
    input logic            clk,
    input logic            reset,
    ula_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t       state;
    state_t       state_nxt;
    logic         last_served;
    logic         gnt_sel;
    logic         gnt_id;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   op_cmd;
    logic [15:0]  wait_cnt;
    logic         any_req;
    logic         done_ok;
    logic         timed_out;

    logic         ack0_q,   ack0_d;
    logic         ack1_q,   ack1_d;
    logic [W-1:0] result_q, result_d;
    logic         carry_q,  carry_d;
    logic         err_q,    err_d;
    logic         busy_q,   busy_d;
    logic         start_q,  start_d;

    assign any_req = bus.req0 | bus.req1;

    // The counter is zero only in the first WAIT cycle, so it doubles as the stale-done guard.
    assign done_ok   = (state == S_WAIT) && (wait_cnt != 16'd0) && bus.ula_done;
    assign timed_out = (state == S_WAIT) && (wait_cnt == CNT_LAST);

    always_comb begin
        gnt_sel = 1'b0;
        if (bus.req0 && bus.req1) begin
            gnt_sel = ~last_served;
        end else if (bus.req1) begin
            gnt_sel = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            last_served <= 1'b1;
            gnt_id      <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_cmd      <= '0;
            wait_cnt    <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            start_q  <= start_d;

            if (state == S_IDLE && any_req) begin
                gnt_id <= gnt_sel;
                op_a   <= gnt_sel ? bus.a1   : bus.a0;
                op_b   <= gnt_sel ? bus.b1   : bus.b0;
                op_cmd <= gnt_sel ? bus.cmd1 : bus.cmd0;
            end

            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            if (state == S_RESP) begin
                last_served <= gnt_id;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done_ok || timed_out) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; a real done wins over a same-cycle timeout.
    always_comb begin
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        result_d = result_q;
        carry_d  = carry_q;
        err_d    = err_q;
        start_d  = (state_nxt == S_ISSUE);
        busy_d   = (state_nxt != S_IDLE);
        if (state == S_WAIT && state_nxt == S_RESP) begin
            ack0_d = ~gnt_id;
            ack1_d = gnt_id;
            if (done_ok) begin
                result_d = bus.ula_result;
                carry_d  = bus.ula_carry;
                err_d    = 1'b0;
            end else begin
                result_d = '0;
                carry_d  = 1'b0;
                err_d    = 1'b1;
            end
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.ula_start = start_q;
    assign bus.ula_a     = op_a;
    assign bus.ula_b     = op_b;
    assign bus.ula_cmd   = op_cmd;
endmodule

// File: doc/ula_scheduler.md
ULA_SCHEDULER -- requirements
Module: ula_scheduler

Interface
REQ-001 Parameter W, default 26, sets the operand and result width.
REQ-002 Parameter TIMEOUT, default 65535, sets the maximum WAIT cycles before an operation is abandoned; the counter is 16 bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1  operation request from requester 0 / 1; held high until the matching ack.
REQ-006 a0, b0 / a1, b1  input  W  operands of requester 0 / 1.
REQ-007 cmd0 / cmd1  input  2  ULA command of requester 0 / 1 (0 mult, 1 add, 2 sub).
REQ-008 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-009 result  output  W  result of the last completed operation.
REQ-010 carry  output  1  carry of the last completed operation.
REQ-011 err  output  1  high when the last completed operation timed out.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 ula_start  output  1  start strobe to the shared ULA.
REQ-014 ula_a, ula_b  output  W  operands to the ULA.
REQ-015 ula_cmd  output  2  command to the ULA.
REQ-016 ula_done  input  1  ULA completion flag; level-sensitive and possibly stale high.
REQ-017 ula_result  input  W  ULA result.
REQ-018 ula_carry  input  1  ULA carry.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs are registered.
REQ-020 IDLE, exactly one req high: grant that requester.
REQ-021 IDLE, both req high: grant the requester not marked last-served (round-robin).
REQ-022 IDLE, no req: stay in IDLE.
REQ-023 On grant: latch the granted a, b and cmd plus the grant id into internal registers, then go to ISSUE.
REQ-024 ISSUE: ula_start = 1 for exactly one cycle; clear the wait counter; go to WAIT.
REQ-025 ula_a, ula_b and ula_cmd are driven from the latched registers and stay stable from ISSUE through the RESP cycle, independent of requester inputs.
REQ-026 WAIT, first cycle: ula_done is ignored (stale-done guard); the counter increments.
REQ-027 WAIT, later cycles, ula_done = 1: capture ula_result into result, ula_carry into carry, set err = 0, go to RESP.
REQ-028 WAIT, counter reaches TIMEOUT-1 without done: set result = 0, carry = 0, err = 1, go to RESP.
REQ-029 RESP: pulse the ack of the granted requester for one cycle; result, carry and err are valid in that cycle and hold until the next RESP.
REQ-030 RESP: update last-served to the granted id, then return to IDLE.
REQ-031 Minimum latency: req seen in IDLE at cycle N gives ula_start at N+1, earliest done sampled at N+3, ack at N+4.
REQ-032 A req dropped mid-operation does not abort the operation; its ack is still issued.
REQ-033 A req changing while busy is not sampled until IDLE.
REQ-034 After RESP, a requester that holds req and contends with the other requester loses the next arbitration.
REQ-035 A requester with no contention may be re-granted immediately.
REQ-036 ack0 and ack1 are never high simultaneously.
REQ-037 ula_start is never high outside ISSUE.

Reset
REQ-038 Reset sampled high sets: state = IDLE, last-served = 1 (requester 0 wins the first tie), counter = 0.
REQ-039 Reset also clears the internal registers and all outputs (ack0, ack1, result, carry, err, busy, ula_start, ula_a, ula_b, ula_cmd) to 0.
REQ-040 Reset mid-operation abandons the operation with no ack; ula_start is 0 from the following cycle.

Verification
REQ-041 req0 = 1, a0 = 3, b0 = 4, cmd0 = 1, model ULA done 1 cycle after start with 7 -> ula_start at N+1, ack0 at N+4, result = 7, carry = 0, err = 0.
REQ-042 req0 and req1 high together after reset, held high -> grant order is 0, 1, 0, 1; ack pulses alternate and are never simultaneous.
REQ-043 ula_done stuck high before start, real done at 5 cycles -> the guard cycle is ignored and ack follows the real done.
REQ-044 TIMEOUT = 8, ula_done held low -> ack at N+1+8+1, err = 1, result = 0; the next operation completes normally with err = 0.
REQ-045 Reset asserted during WAIT -> no ack, busy = 0 and ula_start = 0 the next cycle; a subsequent req0 is served normally.
REQ-046 Operands changed while WAIT -> ula_a, ula_b and ula_cmd keep the latched values; result reflects the latched operation.
